strap_seq_ctrl: RTL and testbench

Parametrised strap controller for the pinmux block. It samples the pad strap bus after external reset, with optional debounce and timeout. It maps the result into a configurable number of software-writable sticky banks, and sequences soft-reboot requests into a timed reset pulse. It sits between the pad ring and the pinmux/reset/clock-control logic as the generalised successor of the fixed 16/32-bit strap controller.

---
 rtl/strap_pkg.sv | 29 ++
 rtl/strap_sampler.sv | 69 ++++++
 rtl/strap_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_strap_seq_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/strap_pkg.sv
// Shared types and helpers for the strap sequencing controller.
// Feature macro: STRAP_DEBOUNCE_EN (debounced pad sampling in strap_sampler).
package strap_pkg;

    typedef enum logic [1:0] {
        SAMPLE = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        REBOOT = 2'd3
    } strap_state_t;

    // Reboot request bit sits at STICKY_W - STRAP_SOFT_REBOOT_BIT (the bank0 MSB).
    localparam int STRAP_SOFT_REBOOT_BIT = 1;

    // Widest strap the mapping helper handles; callers truncate the result.
    localparam int STRAP_MAX_W = 256;

    function automatic logic [STRAP_MAX_W-1:0] map_strap(
        input logic [STRAP_MAX_W-1:0] latch,
        input logic [STRAP_MAX_W-1:0] dflt,
        input logic [7:0]             mode_bit
    );
        logic [STRAP_MAX_W-1:0] sel;
        sel = latch[mode_bit] ? dflt : latch;
        sel[mode_bit] = 1'b0;
        return sel;
    endfunction

endpackage

// File: rtl/strap_sampler.sv
// Pad strap sampler: decides when the strap latch is taken.
// With STRAP_DEBOUNCE_EN it waits for stable samples or a timeout; otherwise it latches at once.
module strap_sampler #(
    parameter int PAD_W      = 16,
    parameter int SAMPLE_CNT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [PAD_W-1:0] pad_strap_in,
    output logic             latch_en,
    output logic             unstable
);
`ifdef STRAP_DEBOUNCE_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [PAD_W-1:0] prev_q, prev_d;
    logic [CW-1:0]    stab_cnt_q, stab_cnt_d;
    logic [CW-1:0]    tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        prev_d     = prev_q;
        stab_cnt_d = stab_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        latch_en   = 1'b0;
        unstable   = 1'b0;
        if (sample_en) begin
            prev_d = pad_strap_in;
            if (tmo_cnt_q != CW'(TIMEOUT))
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            // tmo_cnt still zero marks the first edge, where prev holds nothing useful yet
            if (tmo_cnt_q != '0) begin
                if (pad_strap_in == prev_q) begin
                    if (stab_cnt_q != CW'(TIMEOUT))
                        stab_cnt_d = stab_cnt_q + 1'b1;
                end else begin
                    stab_cnt_d = '0;
                end
            end
            if (tmo_cnt_q != '0 && stab_cnt_d == CW'(SAMPLE_CNT)) begin
                latch_en = 1'b1;
            end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
                latch_en = 1'b1;
                unstable = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            stab_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            prev_q     <= prev_d;
            stab_cnt_q <= stab_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end
`else
    localparam int UNUSED_PARAMS = SAMPLE_CNT + TIMEOUT;
    logic unused_in;

    assign unused_in = ^{clk, rst, pad_strap_in};
    assign latch_en  = sample_en;
    assign unstable  = 1'b0;
`endif
endmodule

// File: rtl/strap_seq_ctrl.sv
// Strap controller: samples pads, loads sticky banks, sequences soft reboots.
// Debounce is enabled by defining STRAP_DEBOUNCE_EN.
module strap_seq_ctrl
    import strap_pkg::*;
#(
    parameter int               PAD_W          = 16,
    parameter int               STICKY_W       = 32,
    parameter int               NUM_BANK       = 2,
    parameter int               MODE_BIT       = 11,
    parameter logic [PAD_W-1:0] PSTRAP_DEFAULT = '0,
    parameter int               SAMPLE_CNT     = 4,
    parameter int               TIMEOUT        = 64,
    parameter int               RST_CYC        = 8,
    localparam int              AW             = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic                         clk,
    input  logic                         e_reset,
    input  logic                         p_reset_n,
    input  logic [PAD_W-1:0]             pad_strap_in,
    input  logic                         cs,
    input  logic [AW-1:0]                addr,
    input  logic [STICKY_W/8-1:0]        we,
    input  logic [STICKY_W-1:0]          data_in,
    output logic [PAD_W-1:0]             strap_latch,
    output logic [NUM_BANK*STICKY_W-1:0] strap_sticky,
    output logic                         strap_valid,
    output logic                         strap_unstable,
    output logic                         soft_reboot_rst
);
    localparam int RCW        = $clog2(RST_CYC + 1);
    localparam int NB         = STICKY_W / 8;
    localparam int REBOOT_IDX = STICKY_W - STRAP_SOFT_REBOOT_BIT;

    strap_state_t         state_q, state_d;
    logic [PAD_W-1:0]     strap_latch_q, strap_latch_d;
    logic [STICKY_W-1:0]  bank_q [NUM_BANK];
    logic [STICKY_W-1:0]  bank_d [NUM_BANK];
    logic                 strap_valid_q, strap_valid_d;
    logic                 strap_unstable_q, strap_unstable_d;
    logic                 soft_rst_q, soft_rst_d;
    logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
    logic                 latch_en, unstable;
    logic [STRAP_MAX_W-1:0] map_full;
    logic [PAD_W-1:0]     pstrap_select;
    logic                 unused_map_hi;
    logic                 reboot_req, rst_done;

    strap_sampler #(
        .PAD_W      (PAD_W),
        .SAMPLE_CNT (SAMPLE_CNT),
        .TIMEOUT    (TIMEOUT)
    ) u_sampler (
        .clk          (clk),
        .rst          (e_reset),
        .sample_en    (state_q == SAMPLE),
        .pad_strap_in (pad_strap_in),
        .latch_en     (latch_en),
        .unstable     (unstable)
    );

    assign map_full      = map_strap(STRAP_MAX_W'(strap_latch_q), STRAP_MAX_W'(PSTRAP_DEFAULT), 8'(MODE_BIT));
    assign pstrap_select = map_full[PAD_W-1:0];
    assign unused_map_hi = ^map_full[STRAP_MAX_W-1:PAD_W];
    assign reboot_req    = bank_q[0][REBOOT_IDX];
    assign rst_done      = (rst_cnt_q == RCW'(RST_CYC - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SAMPLE:  if (latch_en) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (!p_reset_n) state_d = LOAD;
                     else if (reboot_req) state_d = REBOOT;
            REBOOT:  if (!p_reset_n) state_d = LOAD;
                     else if (rst_done) state_d = RUN;
            default: state_d = SAMPLE;
        endcase
    end

    always_comb begin
        strap_latch_d    = strap_latch_q;
        strap_unstable_d = strap_unstable_q;
        for (int b = 0; b < NUM_BANK; b++)
            bank_d[b] = bank_q[b];
        if (state_q == SAMPLE && latch_en) begin
            strap_latch_d    = pad_strap_in;
            strap_unstable_d = unstable;
        end
        if (state_q == LOAD) begin
            for (int b = 0; b < NUM_BANK; b++)
                bank_d[b] = '0;
            bank_d[0] = {{(STICKY_W-PAD_W){1'b0}}, pstrap_select};
        end
        // Reboot entry wins over a same-cycle register write
        if (state_q == RUN && p_reset_n) begin
            if (reboot_req) begin
                bank_d[0][REBOOT_IDX] = 1'b0;
            end else if (cs) begin
                for (int b = 0; b < NUM_BANK; b++)
                    for (int i = 0; i < NB; i++)
                        if (we[i] && int'(addr) == b)
                            bank_d[b][8*i +: 8] = data_in[8*i +: 8];
            end
        end
        rst_cnt_d = '0;
        if (state_q == REBOOT && state_d == REBOOT)
            rst_cnt_d = rst_done ? rst_cnt_q : rst_cnt_q + 1'b1;
        soft_rst_d    = (state_d == REBOOT);
        strap_valid_d = (state_d == RUN) || (state_d == REBOOT);
    end

    always_ff @(posedge clk or posedge e_reset) begin
        if (e_reset) begin
            state_q          <= SAMPLE;
            strap_latch_q    <= '0;
            strap_valid_q    <= 1'b0;
            strap_unstable_q <= 1'b0;
            soft_rst_q       <= 1'b0;
            rst_cnt_q        <= '0;
            for (int b = 0; b < NUM_BANK; b++)
                bank_q[b] <= '0;
        end else begin
            state_q          <= state_d;
            strap_latch_q    <= strap_latch_d;
            strap_valid_q    <= strap_valid_d;
            strap_unstable_q <= strap_unstable_d;
            soft_rst_q       <= soft_rst_d;
            rst_cnt_q        <= rst_cnt_d;
            for (int b = 0; b < NUM_BANK; b++)
                bank_q[b] <= bank_d[b];
        end
    end

    for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_pack
        assign strap_sticky[gi*STICKY_W +: STICKY_W] = bank_q[gi];
    end

    assign strap_latch     = strap_latch_q;
    assign strap_valid     = strap_valid_q;
    assign strap_unstable  = strap_unstable_q;
    assign soft_reboot_rst = soft_rst_q;
endmodule

// File: tb/tb_strap_seq_ctrl.sv
// Directed bench for strap_seq_ctrl; adapts its edge expectations to STRAP_DEBOUNCE_EN.
module tb_strap_seq_ctrl;
`ifdef STRAP_DEBOUNCE_EN
    localparam int VALID_EDGE = 6;
`else
    localparam int VALID_EDGE = 2;
`endif

    logic        clk = 1'b0;
    logic        e_reset;
    logic        p_reset_n;
    logic [15:0] pad_strap_in;
    logic        cs;
    logic [0:0]  addr;
    logic [3:0]  we;
    logic [31:0] data_in;
    logic [15:0] strap_latch;
    logic [63:0] strap_sticky;
    logic        strap_valid;
    logic        strap_unstable;
    logic        soft_reboot_rst;

    int tests_run = 0;
    int tests_failed = 0;

    strap_seq_ctrl #(
        .PSTRAP_DEFAULT (16'h0520)
    ) dut (
        .clk             (clk),
        .e_reset         (e_reset),
        .p_reset_n       (p_reset_n),
        .pad_strap_in    (pad_strap_in),
        .cs              (cs),
        .addr            (addr),
        .we              (we),
        .data_in         (data_in),
        .strap_latch     (strap_latch),
        .strap_sticky    (strap_sticky),
        .strap_valid     (strap_valid),
        .strap_unstable  (strap_unstable),
        .soft_reboot_rst (soft_reboot_rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic [15:0] pad);
        e_reset      = 1'b1;
        p_reset_n    = 1'b1;
        cs           = 1'b0;
        addr         = '0;
        we           = '0;
        data_in      = '0;
        pad_strap_in = pad;
        #12;
        @(negedge clk);
        e_reset = 1'b0;
        $display("[TB] e_reset released, pad=0x%04h", pad);
    endtask

    task automatic write_reg(input logic [0:0] a, input logic [3:0] w, input logic [31:0] d);
        cs      = 1'b1;
        addr    = a;
        we      = w;
        data_in = d;
        tick();
        cs = 1'b0;
        we = '0;
        $display("[TB] write bank%0d we=%b data=0x%08h", a, w, d);
    endtask

    initial begin
        // Reset state
        reset_dut(16'h00A5);
        check("rst_valid",    64'(strap_valid), 64'h0);
        check("rst_latch",    64'(strap_latch), 64'h0);
        check("rst_sticky",   strap_sticky, 64'h0);
        check("rst_soft",     64'(soft_reboot_rst), 64'h0);
        check("rst_unstable", 64'(strap_unstable), 64'h0);

        // Stable pad: valid appears exactly at VALID_EDGE
        repeat (VALID_EDGE - 1) tick();
        check("valid_early", 64'(strap_valid), 64'h0);
        tick();
        check("valid_edge",  64'(strap_valid), 64'h1);
        check("latch_a5",    64'(strap_latch), 64'h00A5);
        check("sticky_a5",   strap_sticky, 64'h0000_0000_0000_00A5);
        check("unstable_a5", 64'(strap_unstable), 64'h0);
        $display("[TB] strap loaded latch=0x%04h", strap_latch);

        // Byte-masked write to bank1
        write_reg(1'b1, 4'b0101, 32'hAABBCCDD);
        check("wr_bank1", strap_sticky, 64'h00BB00DD_000000A5);

        // Reboot request: two edges to pulse, RST_CYC cycles high
        write_reg(1'b0, 4'b1000, 32'h80000000);
        check("rb_bit_set", 64'(strap_sticky[31:0]), 64'h800000A5);
        check("rb_soft_e1", 64'(soft_reboot_rst), 64'h0);
        for (int j = 0; j < 8; j++) begin
            tick();
            cs = 1'b0;
            we = '0;
            check("rb_soft_hi", 64'(soft_reboot_rst), 64'h1);
            if (j == 0) check("rb_bit_clr", 64'(strap_sticky[31:0]), 64'h000000A5);
            if (j == 2) begin
                cs = 1'b1; addr = 1'b1; we = 4'b0001; data_in = 32'h11;
            end
        end
        tick();
        check("rb_soft_lo",   64'(soft_reboot_rst), 64'h0);
        check("rb_valid",     64'(strap_valid), 64'h1);
        check("rb_preserved", strap_sticky, 64'h00BB00DD_000000A5);
        $display("[TB] soft reboot pulse complete");

        // p_reset_n mid-REBOOT: pulse drops, banks reload
        write_reg(1'b0, 4'b1000, 32'h80000000);
        tick();
        check("pr_soft_hi", 64'(soft_reboot_rst), 64'h1);
        tick();
        tick();
        p_reset_n = 1'b0;
        tick();
        p_reset_n = 1'b1;
        check("pr_soft_drop", 64'(soft_reboot_rst), 64'h0);
        check("pr_valid_lo",  64'(strap_valid), 64'h0);
        tick();
        check("pr_valid_hi",  64'(strap_valid), 64'h1);
        check("pr_reload",    strap_sticky, 64'h0000_0000_0000_00A5);
        tick();
        check("pr_run_soft",  64'(soft_reboot_rst), 64'h0);
        check("pr_run_valid", 64'(strap_valid), 64'h1);
        $display("[TB] p_reset_n reload complete");

        // e_reset mid-REBOOT clears the pulse without a clock edge
        write_reg(1'b0, 4'b1000, 32'h80000000);
        tick();
        check("er_soft_hi", 64'(soft_reboot_rst), 64'h1);
        #2;
        e_reset = 1'b1;
        #1;
        check("er_soft_lo", 64'(soft_reboot_rst), 64'h0);
        check("er_sticky",  strap_sticky, 64'h0);
        $display("[TB] e_reset abort of reboot");

        // MODE_BIT set selects the default strap value
        reset_dut(16'h0800);
        repeat (VALID_EDGE) tick();
        check("mode_valid", 64'(strap_valid), 64'h1);
        check("mode_latch", 64'(strap_latch), 64'h0800);
        check("mode_bank0", strap_sticky, 64'h0000_0000_0000_0520);
        $display("[TB] mode strap loaded bank0=0x%08h", strap_sticky[31:0]);

`ifdef STRAP_DEBOUNCE_EN
        // Bouncing pad: timeout latch at edge 64
        reset_dut(16'h1234);
        for (int k = 1; k <= 65; k++) begin
            pad_strap_in = (k % 2 == 1) ? 16'h1234 : 16'h4321;
            tick();
            if (k == 63) begin
                check("tmo_latch_early", 64'(strap_latch), 64'h0);
                check("tmo_unst_early",  64'(strap_unstable), 64'h0);
            end
            if (k == 64) begin
                check("tmo_latch",    64'(strap_latch), 64'h4321);
                check("tmo_unstable", 64'(strap_unstable), 64'h1);
                check("tmo_valid_lo", 64'(strap_valid), 64'h0);
            end
            if (k == 65) begin
                check("tmo_valid_hi", 64'(strap_valid), 64'h1);
                check("tmo_bank0",    strap_sticky, 64'h0000_0000_0000_4321);
            end
        end
        $display("[TB] timeout latch with unstable pad");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
